// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if: SPI pin bundle between an SPI master and the spi_slave_regs block.
interface spi_slave_regs_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport slave (
    input  sclk,
    input  ss_n,
    input  mosi,
    output miso,
    output miso_oe
  );

  modport master (
    output sclk,
    output ss_n,
    output mosi,
    input  miso,
    input  miso_oe
  );
endinterface

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave exposing a 16x8 register file to the fabric side.
// Optional macro SPI_SLAVE_AUTOINC_EN: post-increment the address after every data byte.
module spi_slave_regs #(
  parameter int unsigned CLK_DIV_MIN = 8
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  spi_slave_regs_if.slave        spi,
  input  logic [7:0]             status_in,
  input  logic [3:0]             rd_addr,
  output logic [7:0]             rd_data,
  output logic                   wr_strobe,
  output logic [3:0]             wr_addr,
  output logic [7:0]             wr_data
);

  localparam int unsigned DW      = 8;
  localparam int unsigned AW      = 4;
  localparam int unsigned NREGS   = 16;
  localparam int unsigned CNT_W   = 3;
  localparam logic [AW-1:0] STATUS_ADDR = 4'hF;

  // The synchronizer plus edge detector needs a few clk cycles per sclk phase.
  if (CLK_DIV_MIN < 6) begin : g_div_check
    $error("spi_slave_regs: CLK_DIV_MIN must be at least 6");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_n;
  logic [DW-1:0]       rx_q, rx_n;
  logic [DW-1:0]       tx_q, tx_n;
  logic [AW-1:0]       addr_q, addr_n;
  logic                write_q, write_n;
  logic                miso_q, miso_n;
  logic                miso_oe_q, miso_oe_n;
  logic                wr_strobe_q;
  logic [AW-1:0]       wr_addr_q;
  logic [DW-1:0]       wr_data_q;
  logic [DW-1:0]       rd_data_q;
  logic [DW-1:0]       regs_q [NREGS];

  logic sclk_meta, sclk_s, sclk_d;
  logic ss_meta, ss_s, ss_d;
  logic mosi_meta, mosi_s;

  logic                sclk_rise_c, sclk_fall_c;
  logic                ss_fall_c, ss_rise_c;
  logic [DW-1:0]       rx_byte_c;
  logic [AW-1:0]       addr_inc_c;
  logic [AW-1:0]       load_addr_c;
  logic [DW-1:0]       load_word_c;
  logic                wr_en_c;

  // Two-flop synchronizers; ss_n resets low so a select held across reset never looks like a fresh fall.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_d    <= 1'b0;
      ss_meta   <= 1'b0;
      ss_s      <= 1'b0;
      ss_d      <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sclk_meta <= spi.sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      ss_meta   <= spi.ss_n;
      ss_s      <= ss_meta;
      ss_d      <= ss_s;
      mosi_meta <= spi.mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign sclk_fall_c = ~sclk_s & sclk_d;
  assign ss_fall_c   = ~ss_s & ss_d;
  assign ss_rise_c   = ss_s & ~ss_d;
  assign rx_byte_c   = {rx_q[DW-2:0], mosi_s};

`ifdef SPI_SLAVE_AUTOINC_EN
  assign addr_inc_c = AW'(addr_q + 4'd1);
`else
  assign addr_inc_c = addr_q;
`endif

  // Address of the byte to pre-load into the MISO shifter when a byte completes.
  assign load_addr_c = (state_q == CMD) ? rx_byte_c[AW-1:0] : addr_inc_c;
  assign load_word_c = (load_addr_c == STATUS_ADDR) ? status_in : regs_q[load_addr_c];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_n;
      bit_cnt_q   <= bit_cnt_n;
      rx_q        <= rx_n;
      tx_q        <= tx_n;
      addr_q      <= addr_n;
      write_q     <= write_n;
      miso_q      <= miso_n;
      miso_oe_q   <= miso_oe_n;
      wr_strobe_q <= wr_en_c;
      if (wr_en_c) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte_c;
      end
      // Same-edge read of an address being written returns the pre-write value.
      rd_data_q <= (rd_addr == STATUS_ADDR) ? status_in : regs_q[rd_addr];
    end
  end

  // Register file; the status address is strobed but never stored.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c && (addr_q != STATUS_ADDR)) begin
      regs_q[addr_q] <= rx_byte_c;
    end
  end

  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    rx_n      = rx_q;
    tx_n      = tx_q;
    addr_n    = addr_q;
    write_n   = write_q;
    miso_n    = miso_q;
    miso_oe_n = miso_oe_q;
    wr_en_c   = 1'b0;

    case (state_q)
      IDLE: begin
        miso_n    = 1'b0;
        miso_oe_n = 1'b0;
        if (ss_fall_c) begin
          state_n   = CMD;
          bit_cnt_n = '0;
          rx_n      = '0;
          tx_n      = status_in;
          miso_n    = status_in[DW-1];
          miso_oe_n = 1'b1;
        end
      end

      CMD, DATA: begin
        if (ss_rise_c) begin
          // Deselect drops any partial byte.
          state_n   = IDLE;
          bit_cnt_n = '0;
          rx_n      = '0;
          tx_n      = '0;
          miso_n    = 1'b0;
          miso_oe_n = 1'b0;
        end else if (sclk_rise_c) begin
          rx_n      = rx_byte_c;
          bit_cnt_n = CNT_W'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              state_n = DATA;
              addr_n  = rx_byte_c[AW-1:0];
              write_n = rx_byte_c[DW-1];
              tx_n    = rx_byte_c[DW-1] ? status_in : load_word_c;
            end else begin
              wr_en_c = write_q;
              addr_n  = addr_inc_c;
              tx_n    = write_q ? status_in : load_word_c;
            end
          end
        end else if (sclk_fall_c) begin
          // The fall after a completed byte presents the freshly loaded MSB instead of shifting.
          if (bit_cnt_q != '0) begin
            tx_n = {tx_q[DW-2:0], 1'b0};
          end
          miso_n = tx_n[DW-1];
        end
      end

      default: begin
        state_n   = IDLE;
        miso_n    = 1'b0;
        miso_oe_n = 1'b0;
      end
    endcase
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = miso_oe_q;
  assign rd_data     = rd_data_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: scoreboard bench driving SPI mode-0 transfers at clk/8 into spi_slave_regs.
module tb_spi_slave_regs;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] status_in;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_wr_q [$];
  logic [19:0] obs_wr_q [$];
  logic [7:0]  exp_miso_q [$];

  spi_slave_regs_if spi_bus ();

  spi_slave_regs #(.CLK_DIV_MIN(8)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi           (spi_bus.slave),
    .status_in     (status_in),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  always #5 clk_clk = ~clk_clk;

  // Every cycle with wr_strobe high is one observed write, with rd_data snapshotted alongside.
  always @(negedge clk_clk) begin
    if (reset_reset_n && wr_strobe) obs_wr_q.push_back({wr_addr, wr_data, rd_data});
  end

  task automatic spi_begin();
    @(negedge clk_clk);
    spi_bus.ss_n = 1'b0;
    repeat (8) @(negedge clk_clk);
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk_clk);
    spi_bus.ss_n = 1'b1;
    repeat (8) @(negedge clk_clk);
  endtask

  // Shift n MSB-first bits at sclk = clk/8; MISO is captured at each rising sclk.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_bus.mosi = tx[i];
      repeat (4) @(negedge clk_clk);
      rx = {rx[6:0], spi_bus.miso};
      spi_bus.sclk = 1'b1;
      repeat (4) @(negedge clk_clk);
      spi_bus.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    spi_bus.sclk  = 1'b0;
    spi_bus.ss_n  = 1'b1;
    spi_bus.mosi  = 1'b0;
    status_in     = 8'h00;
    rd_addr       = 4'h0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    total++; if (spi_bus.miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b expected 0", spi_bus.miso); end
    total++; if (spi_bus.miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe: got %b expected 0", spi_bus.miso_oe); end
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    total++; if (wr_addr !== 4'h0) begin bad++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    rd_addr = 4'h3;
    @(negedge clk_clk);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_reg3: got %h expected 00", rd_data); end
  endtask

  task automatic test_write();
    logic [7:0]  rx;
    logic [11:0] e;
    logic [19:0] o;
    spi_begin();
    spi_bits(8'h83, 8, rx);
    spi_bits(8'hA5, 8, rx);
    exp_wr_q.push_back({4'h3, 8'hA5});
    spi_end();
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      total++;
      if (obs_wr_q.size() == 0) begin bad++; $display("FAIL write_strobe: got none expected %h", e); end
      else begin
        o = obs_wr_q.pop_front();
        if (o[19:8] !== e) begin bad++; $display("FAIL write_strobe: got %h expected %h", o[19:8], e); end
      end
    end
    total++; if (obs_wr_q.size() != 0) begin bad++; $display("FAIL write_extra: got %0d extra expected 0", obs_wr_q.size()); obs_wr_q.delete(); end
    rd_addr = 4'h3;
    @(negedge clk_clk);
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL write_readback: got %h expected a5", rd_data); end
  endtask

  task automatic test_read();
    logic [7:0] rx;
    logic [7:0] e;
    status_in = 8'h5C;
    spi_begin();
    total++; if (spi_bus.miso_oe !== 1'b1) begin bad++; $display("FAIL read_oe: got %b expected 1", spi_bus.miso_oe); end
    exp_miso_q.push_back(8'h5C);
    spi_bits(8'h03, 8, rx);
    e = exp_miso_q.pop_front();
    total++; if (rx !== e) begin bad++; $display("FAIL read_status: got %h expected %h", rx, e); end
    exp_miso_q.push_back(8'hA5);
    spi_bits(8'h00, 8, rx);
    e = exp_miso_q.pop_front();
    total++; if (rx !== e) begin bad++; $display("FAIL read_data: got %h expected %h", rx, e); end
    spi_end();
    total++; if ({spi_bus.miso_oe, spi_bus.miso} !== 2'b00) begin bad++; $display("FAIL read_idle_pins: got %b expected 00", {spi_bus.miso_oe, spi_bus.miso}); end
    total++; if (obs_wr_q.size() != 0) begin bad++; $display("FAIL read_no_strobe: got %0d expected 0", obs_wr_q.size()); obs_wr_q.delete(); end
  endtask

  task automatic test_autoinc();
    logic [7:0]  rx;
    logic [11:0] e;
    logic [19:0] o;
    logic [7:0]  exp_reg0;
    spi_begin();
    spi_bits(8'h8F, 8, rx);
    spi_bits(8'h11, 8, rx);
    exp_wr_q.push_back({4'hF, 8'h11});
    spi_bits(8'h22, 8, rx);
`ifdef SPI_SLAVE_AUTOINC_EN
    exp_wr_q.push_back({4'h0, 8'h22});
    exp_reg0 = 8'h22;
`else
    exp_wr_q.push_back({4'hF, 8'h22});
    exp_reg0 = 8'h00;
`endif
    spi_end();
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      total++;
      if (obs_wr_q.size() == 0) begin bad++; $display("FAIL autoinc_strobe: got none expected %h", e); end
      else begin
        o = obs_wr_q.pop_front();
        if (o[19:8] !== e) begin bad++; $display("FAIL autoinc_strobe: got %h expected %h", o[19:8], e); end
      end
    end
    total++; if (obs_wr_q.size() != 0) begin bad++; $display("FAIL autoinc_extra: got %0d extra expected 0", obs_wr_q.size()); obs_wr_q.delete(); end
    rd_addr = 4'h0;
    @(negedge clk_clk);
    total++; if (rd_data !== exp_reg0) begin bad++; $display("FAIL autoinc_reg0: got %h expected %h", rd_data, exp_reg0); end
    rd_addr = 4'hF;
    @(negedge clk_clk);
    total++; if (rd_data !== status_in) begin bad++; $display("FAIL autoinc_regF: got %h expected %h", rd_data, status_in); end
  endtask

  task automatic test_collision();
    logic [7:0]  rx;
    logic [19:0] o;
    rd_addr = 4'h4;
    spi_begin();
    spi_bits(8'h84, 8, rx);
    spi_bits(8'h77, 8, rx);
    spi_end();
    total++;
    if (obs_wr_q.size() != 1) begin bad++; $display("FAIL collision_strobe: got %0d strobes expected 1", obs_wr_q.size()); obs_wr_q.delete(); end
    else begin
      o = obs_wr_q.pop_front();
      total++; if (o !== {4'h4, 8'h77, 8'h00}) begin bad++; $display("FAIL collision_old: got %h expected 47700", o); end
    end
    total++; if (rd_data !== 8'h77) begin bad++; $display("FAIL collision_new: got %h expected 77", rd_data); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    spi_begin();
    spi_bits(8'h81, 8, rx);
    spi_bits(8'hF0, 4, rx);
    spi_end();
    total++; if (obs_wr_q.size() != 0) begin bad++; $display("FAIL abort_strobe: got %0d expected 0", obs_wr_q.size()); obs_wr_q.delete(); end
    rd_addr = 4'h1;
    @(negedge clk_clk);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL abort_reg1: got %h expected 00", rd_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  rx;
    logic [11:0] e;
    logic [19:0] o;
    rd_addr = 4'h3;
    spi_begin();
    spi_bits(8'h82, 8, rx);
    spi_bits(8'hC3, 4, rx);
    #2;
    reset_reset_n = 1'b0;
    #1;
    total++; if ({spi_bus.miso_oe, spi_bus.miso, wr_strobe} !== 3'b000) begin bad++; $display("FAIL rstmid_pins: got %b expected 000", {spi_bus.miso_oe, spi_bus.miso, wr_strobe}); end
    total++; if ({wr_addr, wr_data, rd_data} !== 20'h0) begin bad++; $display("FAIL rstmid_regs: got %h expected 00000", {wr_addr, wr_data, rd_data}); end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    // Select is still low: the block must stay silent until a new falling edge.
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h5A, 8, rx);
    total++; if (spi_bus.miso_oe !== 1'b0) begin bad++; $display("FAIL rstmid_stale_oe: got %b expected 0", spi_bus.miso_oe); end
    spi_end();
    total++; if (obs_wr_q.size() != 0) begin bad++; $display("FAIL rstmid_no_strobe: got %0d expected 0", obs_wr_q.size()); obs_wr_q.delete(); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rstmid_reg3_cleared: got %h expected 00", rd_data); end
    spi_begin();
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h3C, 8, rx);
    exp_wr_q.push_back({4'h2, 8'h3C});
    spi_end();
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      total++;
      if (obs_wr_q.size() == 0) begin bad++; $display("FAIL rstmid_strobe: got none expected %h", e); end
      else begin
        o = obs_wr_q.pop_front();
        if (o[19:8] !== e) begin bad++; $display("FAIL rstmid_strobe: got %h expected %h", o[19:8], e); end
      end
    end
    total++; if (obs_wr_q.size() != 0) begin bad++; $display("FAIL rstmid_extra: got %0d extra expected 0", obs_wr_q.size()); obs_wr_q.delete(); end
    rd_addr = 4'h2;
    @(negedge clk_clk);
    total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL rstmid_reg2: got %h expected 3c", rd_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_autoinc();
    test_collision();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter CLK_DIV_MIN, default 8, meaning the minimum ratio of clk_clk to spi_sclk frequency that the block supports.
REQ-002 SHALL have port clk_clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port spi_sclk, input, 1, SPI serial clock from the master, asynchronous to clk_clk.
REQ-005 SHALL have port spi_ss_n, input, 1, active-low slave select, asynchronous.
REQ-006 SHALL have port spi_mosi, input, 1, master-out serial data, asynchronous.
REQ-007 SHALL have port spi_miso, output, 1, slave-out serial data.
REQ-008 SHALL have port spi_miso_oe, output, 1, MISO drive enable; 1 only while selected.
REQ-009 SHALL have port status_in, input, 8, read-only status byte returned at address 0xF and during every command byte.
REQ-010 SHALL have port rd_addr, input, 4, fabric-side register read address.
REQ-011 SHALL have port rd_data, output, 8, registered read data for rd_addr, 1-cycle latency.
REQ-012 SHALL have port wr_strobe, output, 1, one-cycle pulse per completed SPI write byte.
REQ-013 SHALL have port wr_addr, output, 4, address of the last SPI write; valid with wr_strobe.
REQ-014 SHALL have port wr_data, output, 8, data of the last SPI write; valid with wr_strobe.

Function
REQ-015 SHALL pass spi_sclk, spi_ss_n and spi_mosi through 2-flop synchronizers and detect edges from the synchronized sclk only.
REQ-016 SHALL implement SPI mode 0, MSB first: sample MOSI on sclk rise; update MISO on sclk fall.
REQ-017 SHALL use FSM states IDLE, CMD and DATA; IDLE->CMD on synchronized ss_n fall; CMD->DATA after 8 bits; ss_n rise from any state returns to IDLE.
REQ-018 SHALL, on entry to CMD, load the MISO shifter with status_in so that bit 7 is on spi_miso before the first sclk rise.
REQ-019 SHALL decode the command byte as bit7=1 write, bit7=0 read, bits3:0 = start address, and ignore bits6:4.
REQ-020 SHALL, for a read, load the register file value at the current address into the MISO shifter within 2 clk_clk cycles of the command byte's 8th rise; address 0xF returns status_in.
REQ-021 SHALL, for a write, store each 8th-bit data byte into the 16x8 register file at the current address and pulse wr_strobe with wr_addr and wr_data one cycle later.
REQ-022 SHALL ignore writes to address 0xF for storage but still pulse wr_strobe for them.
REQ-023 SHALL, on ss_n deassert mid-byte, discard the partial byte: no write and no strobe.
REQ-024 SHALL drive spi_miso to 0 and spi_miso_oe to 0 in IDLE.
REQ-025 SHALL, when the fabric reads the same address that an SPI write updates in the same cycle, return the old value on rd_data; the new value SHALL appear on the next read.

Reset
REQ-026 SHALL, with reset_reset_n=0, set the FSM to IDLE, all register file entries to 0x00, the shifters and bit counter to 0, and spi_miso, spi_miso_oe, rd_data, wr_strobe, wr_addr and wr_data to 0.
REQ-027 SHALL, when reset is asserted mid-transaction, abort the transfer without a strobe and require a fresh ss_n fall before responding again.

Configuration
REQ-028 SHALL, with SPI_SLAVE_AUTOINC_EN defined, increment the address after each data byte in DATA, wrapping 0xF->0x0.
REQ-029 SHALL, without SPI_SLAVE_AUTOINC_EN, keep the address fixed at the command address for all data bytes of the transaction.

Verification
REQ-030 SHALL cover: reset release, then check that all outputs are 0 and rd_addr=3 gives rd_data=0x00 after 1 cycle.
REQ-031 SHALL cover: SPI bytes 0x83,0xA5 with sclk=clk/8 -> wr_strobe pulses once with wr_addr=3 and wr_data=0xA5; rd_addr=3 then gives 0xA5.
REQ-032 SHALL cover: status_in=0x5C, SPI bytes 0x03,0x00 -> MISO returns 0x5C then 0xA5.
REQ-033 SHALL cover: SPI bytes 0x8F,0x11,0x22 with AUTOINC -> writes to 0xF (strobe, no store) then 0x0=0x22; without AUTOINC, both strobes go to 0xF.
REQ-034 SHALL cover: SPI byte 0x81 then 4 bits of the data byte, then ss_n rise -> no wr_strobe and register 1 unchanged.
REQ-035 SHALL cover: reset_reset_n pulsed low during a data byte -> outputs go to 0 asynchronously; the next full transaction completes correctly.
